// File: rtl/hazard_stall_controller_pkg.sv
// hazard_pkg: definitions shared by the hazard stall controller, its interface
// and the optional performance counters.
//   hazard_state_e : sequencing FSM states (RUN, MD_WAIT)
//   REG_ADDR_W_DEF : default register address width
//   ZERO_REG       : hard-wired zero register, never a real load-use hazard
//   MD_LATENCY_MIN/MAX : legal range for the mul/div occupancy of EX
//   md_wait_init() : initial md_cnt value when entering MD_WAIT
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } hazard_state_e;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int ZERO_REG       = 0;
   localparam int MD_LATENCY_MIN = 1;
   localparam int MD_LATENCY_MAX = 16;
   localparam int MD_CNT_W       = 4;

   // The issue cycle is spent in RUN and md_cnt counts down through 0, so
   // MD_WAIT lasts latency-1 cycles when loaded with latency-2.
   function automatic logic [MD_CNT_W-1:0] md_wait_init(input int latency);
      if (latency > 1)
         return MD_CNT_W'(latency - 2);
      else
         return '0;
   endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID/EX hazard inputs and pipeline-register
// control outputs of the hazard stall controller.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : controller side (receives hazard inputs, drives controls)
// Parameter REG_ADDR_W sets the register address width.
interface hazard_stall_controller_if
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
   // hazard inputs
   logic [REG_ADDR_W-1:0] IF_ID_reg_rs;
   logic [REG_ADDR_W-1:0] IF_ID_reg_rt;
   logic                  IF_ID_use_rs;
   logic                  IF_ID_use_rt;
   logic                  ID_EX_memRead;
   logic [REG_ADDR_W-1:0] ID_EX_reg_rt;
   logic                  ID_mdStart;
   logic                  EX_branch_taken;
   // pipeline controls
   logic                  pc_write;
   logic                  IF_ID_write;
   logic                  IF_ID_flush;
   logic                  ID_EX_write;
   logic                  ID_EX_bubble;
   logic                  EX_MEM_bubble;
   logic                  md_busy;

   modport master (
      output IF_ID_reg_rs, IF_ID_reg_rt, IF_ID_use_rs, IF_ID_use_rt,
             ID_EX_memRead, ID_EX_reg_rt, ID_mdStart, EX_branch_taken,
      input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
             ID_EX_bubble, EX_MEM_bubble, md_busy
   );

   modport slave (
      input  IF_ID_reg_rs, IF_ID_reg_rt, IF_ID_use_rs, IF_ID_use_rt,
             ID_EX_memRead, ID_EX_reg_rt, ID_mdStart, EX_branch_taken,
      output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
             ID_EX_bubble, EX_MEM_bubble, md_busy
   );

endinterface

// File: rtl/hazard_stall_controller_perf_counters.sv
// hazard_perf_counters: saturating event counters for the hazard controller.
//   clk, reset     : core clock, synchronous active-high reset (clears both)
//   stall          : a non-reset cycle in which the PC was held
//   flush          : a taken-branch flush this cycle
//   stall_cycles   : 32-bit saturating count of stall cycles
//   flush_count    : 16-bit saturating count of branch flushes
module hazard_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   logic [31:0] stall_cycles_reg;
   logic [15:0] flush_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (stall && (stall_cycles_reg != '1))
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (flush && (flush_count_reg != '1))
            flush_count_reg <= flush_count_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decides each cycle which pipeline registers
// advance, hold or take a bubble in the 5-stage core. Handles load-use
// stalls, taken-branch flushes and the front-end hold while a multi-cycle
// mul/div occupies EX.
//   clk, reset : core clock, synchronous active-high reset
//   hz         : hazard_stall_controller_if.slave (hazard inputs, controls)
//   stall_cycles, flush_count : performance counters, present only when
//                               HAZARD_PERF_CNT_EN is defined
// Parameters: MD_LATENCY (1..16) EX occupancy of a mul/div,
//             REG_ADDR_W register address width.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   hazard_stall_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]               stall_cycles,
   output logic [15:0]               flush_count
`endif
);

   localparam logic                MD_MULTI    = (MD_LATENCY > 1);
   localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = md_wait_init(MD_LATENCY);

   hazard_state_e         state_reg, state_next;
   logic [MD_CNT_W-1:0]   md_cnt_reg, md_cnt_next;

   // ---------------- load-use detection ----------------
   logic [REG_ADDR_W-1:0] load_rt;
   logic [REG_ADDR_W-1:0] src_reg [2];
   logic [1:0]            src_use;
   logic [1:0]            src_hit;
   logic                  load_use;

   assign load_rt    = hz.ID_EX_reg_rt;
   assign src_reg[0] = hz.IF_ID_reg_rs;
   assign src_reg[1] = hz.IF_ID_reg_rt;
   assign src_use    = {hz.IF_ID_use_rt, hz.IF_ID_use_rs};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_use[gi] && (src_reg[gi] == load_rt);
      end
   endgenerate

   // A load into the zero register produces nothing to wait for.
   assign load_use = hz.ID_EX_memRead &&
                     (load_rt != REG_ADDR_W'(ZERO_REG)) &&
                     (|src_hit);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= RUN;
         md_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         md_cnt_reg <= md_cnt_next;
      end
   end

   logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_write;
   logic ID_EX_bubble, EX_MEM_bubble, md_busy;
   logic branch_flush;

   always_comb begin
      state_next    = state_reg;
      md_cnt_next   = md_cnt_reg;
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_bubble = 1'b0;
      md_busy       = 1'b0;
      branch_flush  = 1'b0;

      if (reset) begin
         // Freeze the front end and fill the back end with NOPs.
         state_next    = RUN;
         md_cnt_next   = '0;
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_bubble  = 1'b1;
         EX_MEM_bubble = 1'b1;
      end else begin
         unique case (state_reg)
            RUN: begin
               if (hz.EX_branch_taken) begin
                  // Wrong-path instructions in IF/ID go away, including a
                  // mul/div that would otherwise have issued.
                  IF_ID_flush  = 1'b1;
                  ID_EX_bubble = 1'b1;
                  branch_flush = 1'b1;
               end else if (load_use) begin
                  // The load moves to MEM this edge, so this resolves after
                  // exactly one bubble; a mul/div in ID waits with it.
                  pc_write     = 1'b0;
                  IF_ID_write  = 1'b0;
                  ID_EX_bubble = 1'b1;
               end else if (hz.ID_mdStart && MD_MULTI) begin
                  state_next  = MD_WAIT;
                  md_cnt_next = MD_CNT_INIT;
               end
            end
            MD_WAIT: begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_bubble = 1'b1;
               md_busy       = 1'b1;
               if (md_cnt_reg == '0)
                  state_next = RUN;
               else
                  md_cnt_next = md_cnt_reg - 1'b1;
            end
            default: begin
               state_next  = RUN;
               md_cnt_next = '0;
            end
         endcase
      end
   end

   assign hz.pc_write      = pc_write;
   assign hz.IF_ID_write   = IF_ID_write;
   assign hz.IF_ID_flush   = IF_ID_flush;
   assign hz.ID_EX_write   = ID_EX_write;
   assign hz.ID_EX_bubble  = ID_EX_bubble;
   assign hz.EX_MEM_bubble = EX_MEM_bubble;
   assign hz.md_busy       = md_busy;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters u_perf (
      .clk          (clk),
      .reset        (reset),
      .stall        (~pc_write & ~reset),
      .flush        (branch_flush),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`else
   logic unused_flush;
   assign unused_flush = branch_flush;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_stall_controller_if #(.REG_ADDR_W(5)) hz0 ();
   hazard_stall_controller_if #(.REG_ADDR_W(5)) hz1 ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, stall_cycles1;
   logic [15:0] flush_count, flush_count1;
`endif

   hazard_stall_controller #(.MD_LATENCY(4), .REG_ADDR_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz0)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   hazard_stall_controller #(.MD_LATENCY(1), .REG_ADDR_W(5)) dut1 (
      .clk   (clk),
      .reset (reset),
      .hz    (hz1)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles1),
      .flush_count  (flush_count1)
`endif
   );

   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, md_busy}
   logic [6:0] outs0, outs1;
   assign outs0 = {hz0.pc_write, hz0.IF_ID_write, hz0.IF_ID_flush, hz0.ID_EX_write,
                   hz0.ID_EX_bubble, hz0.EX_MEM_bubble, hz0.md_busy};
   assign outs1 = {hz1.pc_write, hz1.IF_ID_write, hz1.IF_ID_flush, hz1.ID_EX_write,
                   hz1.ID_EX_bubble, hz1.EX_MEM_bubble, hz1.md_busy};

   localparam logic [6:0] O_ADV    = 7'b1101000;
   localparam logic [6:0] O_LDUSE  = 7'b0001100;
   localparam logic [6:0] O_BRANCH = 7'b1111100;
   localparam logic [6:0] O_MDWAIT = 7'b0000011;
   localparam logic [6:0] O_RESET  = 7'b0010110;

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      hz0.IF_ID_reg_rs = 5'd1;  hz0.IF_ID_reg_rt = 5'd2;
      hz0.IF_ID_use_rs = 1'b1;  hz0.IF_ID_use_rt = 1'b1;
      hz0.ID_EX_memRead = 1'b0; hz0.ID_EX_reg_rt = 5'd3;
      hz0.ID_mdStart = 1'b0;    hz0.EX_branch_taken = 1'b0;
      hz1.IF_ID_reg_rs = 5'd1;  hz1.IF_ID_reg_rt = 5'd2;
      hz1.IF_ID_use_rs = 1'b1;  hz1.IF_ID_use_rt = 1'b1;
      hz1.ID_EX_memRead = 1'b0; hz1.ID_EX_reg_rt = 5'd3;
      hz1.ID_mdStart = 1'b0;    hz1.EX_branch_taken = 1'b0;
   endtask

   task automatic set_load_use();
      hz0.ID_EX_memRead = 1'b1; hz0.ID_EX_reg_rt = 5'd8;
      hz0.IF_ID_reg_rs = 5'd8;  hz0.IF_ID_use_rs = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      hz0.EX_branch_taken = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (outs0 !== O_RESET) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", outs0, O_RESET);
      end
      $display("test_reset: outs=%b", outs0);
      tick();
      reset = 1'b0;
      set_idle();
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_reset release: outs=%b", outs0);
   endtask

   task automatic test_load_use();
      tick();
      set_idle();
      set_load_use();
      @(negedge clk);
      checks++;
      if (outs0 !== O_LDUSE) begin
         errors++;
         $display("FAIL load_use_rs got=%b exp=%b", outs0, O_LDUSE);
      end
      $display("test_load_use rs hit: outs=%b", outs0);
      tick();
      set_idle();   // load has moved to MEM
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL load_use_release got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use after: outs=%b", outs0);
      // load into r0: no stall
      tick();
      set_idle();
      set_load_use();
      hz0.ID_EX_reg_rt = 5'd0; hz0.IF_ID_reg_rs = 5'd0;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL load_use_r0 got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use r0: outs=%b", outs0);
      // rs matches but is not read: no stall
      tick();
      set_idle();
      set_load_use();
      hz0.IF_ID_use_rs = 1'b0;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL load_use_unused_rs got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use use_rs=0: outs=%b", outs0);
      // rt path
      tick();
      set_idle();
      hz0.ID_EX_memRead = 1'b1; hz0.ID_EX_reg_rt = 5'd17;
      hz0.IF_ID_reg_rt = 5'd17; hz0.IF_ID_use_rt = 1'b1;
      @(negedge clk);
      checks++;
      if (outs0 !== O_LDUSE) begin
         errors++;
         $display("FAIL load_use_rt got=%b exp=%b", outs0, O_LDUSE);
      end
      $display("test_load_use rt hit: outs=%b", outs0);
      // rt matches but is not read
      hz0.IF_ID_use_rt = 1'b0;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL load_use_unused_rt got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use use_rt=0: outs=%b", outs0);
   endtask

   task automatic test_branch();
      tick();
      set_idle();
      hz0.EX_branch_taken = 1'b1;
      hz0.ID_mdStart = 1'b1;
      set_load_use();
      @(negedge clk);
      checks++;
      if (outs0 !== O_BRANCH) begin
         errors++;
         $display("FAIL branch_flush got=%b exp=%b", outs0, O_BRANCH);
      end
      $display("test_branch: outs=%b", outs0);
      tick();
      set_idle();
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL branch_no_md got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_branch next: outs=%b", outs0);
   endtask

   task automatic test_md_hold();
      tick();
      set_idle();
      hz0.ID_mdStart = 1'b1;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL md_issue got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_md_hold issue: outs=%b", outs0);
      for (int i = 0; i < 3; i++) begin
         tick();
         set_idle();
         // hazards arriving during the wait must be ignored
         if (i == 0) hz0.EX_branch_taken = 1'b1;
         if (i == 1) set_load_use();
         if (i == 2) hz0.ID_mdStart = 1'b1;
         @(negedge clk);
         checks++;
         if (outs0 !== O_MDWAIT) begin
            errors++;
            $display("FAIL md_wait_%0d got=%b exp=%b", i, outs0, O_MDWAIT);
         end
         $display("test_md_hold wait %0d: outs=%b", i, outs0);
      end
      tick();
      set_idle();
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL md_done got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_md_hold done: outs=%b", outs0);
   endtask

   task automatic test_md_lat1();
      tick();
      set_idle();
      hz1.ID_mdStart = 1'b1;
      @(negedge clk);
      checks++;
      if (outs1 !== O_ADV) begin
         errors++;
         $display("FAIL md_lat1_issue got=%b exp=%b", outs1, O_ADV);
      end
      tick();
      set_idle();
      @(negedge clk);
      checks++;
      if (outs1 !== O_ADV) begin
         errors++;
         $display("FAIL md_lat1_no_wait got=%b exp=%b", outs1, O_ADV);
      end
      $display("test_md_lat1: outs=%b", outs1);
   endtask

   task automatic test_load_use_md();
      tick();
      set_idle();
      set_load_use();
      hz0.ID_mdStart = 1'b1;
      @(negedge clk);
      checks++;
      if (outs0 !== O_LDUSE) begin
         errors++;
         $display("FAIL lu_md_stall got=%b exp=%b", outs0, O_LDUSE);
      end
      $display("test_load_use_md stall: outs=%b", outs0);
      tick();
      set_idle();
      hz0.ID_mdStart = 1'b1;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL lu_md_issue got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use_md issue: outs=%b", outs0);
      for (int i = 0; i < 3; i++) begin
         tick();
         set_idle();
         @(negedge clk);
         checks++;
         if (outs0 !== O_MDWAIT) begin
            errors++;
            $display("FAIL lu_md_wait_%0d got=%b exp=%b", i, outs0, O_MDWAIT);
         end
      end
      tick();
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL lu_md_done got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_load_use_md done: outs=%b", outs0);
   endtask

   task automatic test_reset_mid_wait();
      tick();
      set_idle();
      hz0.ID_mdStart = 1'b1;
      tick();
      set_idle();
      @(negedge clk);
      checks++;
      if (outs0 !== O_MDWAIT) begin
         errors++;
         $display("FAIL rst_wait1 got=%b exp=%b", outs0, O_MDWAIT);
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (outs0 !== O_RESET) begin
         errors++;
         $display("FAIL rst_mid_wait got=%b exp=%b", outs0, O_RESET);
      end
      $display("test_reset_mid_wait in reset: outs=%b", outs0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (outs0 !== O_ADV) begin
         errors++;
         $display("FAIL rst_after_wait got=%b exp=%b", outs0, O_ADV);
      end
      $display("test_reset_mid_wait released: outs=%b", outs0);
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_counters();
      tick();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, flush_count);
      end
      set_load_use();           // 1 stall
      tick();
      set_idle();
      tick();
      hz0.ID_mdStart = 1'b1;    // issue, then 3 wait cycles
      tick();
      set_idle();
      tick(); tick(); tick();
      hz0.EX_branch_taken = 1'b1;
      tick();
      set_idle();
      tick();
      hz0.EX_branch_taken = 1'b1;
      tick();
      set_idle();
      @(negedge clk);
      checks++;
      if (stall_cycles !== 32'd4 || flush_count !== 16'd2) begin
         errors++;
         $display("FAIL perf_counts got=%0d/%0d exp=4/2", stall_cycles, flush_count);
      end
      $display("test_perf_counters: stall=%0d flush=%0d", stall_cycles, flush_count);
   endtask
`endif

   initial begin
      reset = 1'b1;
      set_idle();
      test_reset();
      test_load_use();
      test_branch();
      test_md_hold();
      test_md_lat1();
      test_load_use_md();
      test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
